shift_cmd_queue: RTL

Upstream stage for the shifter. It accepts shift commands (operand, amount, direction, arithmetic flag) from the producer over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It presents them, oldest first, to the shifter over a second valid/ready handshake, so the producer is decoupled from shifter backpressure.

---
 rtl/shift_cmd_queue_pkg.sv | 21 ++
 rtl/shift_cmd_queue_fifo_ctrl.sv | 49 ++++
 rtl/shift_cmd_queue.sv | 74 +++++++
 3 files changed

// File: rtl/shift_cmd_queue_pkg.sv
// shift_cmd_queue_pkg: command entry layout and direction constants shared with the shifter
package shift_cmd_queue_pkg;
    localparam int DEF_SIZE  = 32;
    localparam int DEF_AMT_W = 5;
    localparam int DATA_LSB  = 0;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    // Entry layout, LSB first: data, amt, dir, arith
    function automatic int amt_lsb(int size);
        return size;
    endfunction
    function automatic int dir_bit(int size, int amt_w);
        return size + amt_w;
    endfunction
    function automatic int arith_bit(int size, int amt_w);
        return size + amt_w + 1;
    endfunction
    function automatic int cmd_w(int size, int amt_w);
        return size + amt_w + 2;
    endfunction
endpackage

// File: rtl/shift_cmd_queue_fifo_ctrl.sv
// sync_fifo_ctrl: pointers, occupancy count, full/empty and flush for a power-of-two FIFO
module sync_fifo_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic             out_ready_i,
    output logic             push_o,
    output logic [PTR_W-1:0] wptr_o,
    output logic [PTR_W-1:0] rptr_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             pop;

    assign full_o  = count_q == (PTR_W+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign push_o  = in_valid_i & ~full_o & ~flush_i;
    assign pop     = out_ready_i & ~empty_o & ~flush_i;
    assign wptr_o  = wptr_q;
    assign rptr_o  = rptr_q;
    assign count_o = count_q;

    // Next state: flush clears everything; pointers wrap naturally at DEPTH
    always_comb begin
        wptr_d  = flush_i ? '0 : wptr_q + PTR_W'(push_o);
        rptr_d  = flush_i ? '0 : rptr_q + PTR_W'(pop);
        count_d = flush_i ? '0 : count_q + (PTR_W+1)'(push_o) - (PTR_W+1)'(pop);
    end

    // Control state register, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/shift_cmd_queue.sv
// shift_cmd_queue: DEPTH-entry command FIFO decoupling the producer from shifter backpressure
module shift_cmd_queue
    import shift_cmd_queue_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int AMT_W = DEF_AMT_W,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  out_data,
    output logic [AMT_W-1:0] out_amt,
    output logic             out_dir,
    output logic             out_arith,
    output logic [PTR_W:0]   count
);
    localparam int W  = cmd_w(SIZE, AMT_W);
    localparam int AL = amt_lsb(SIZE);
    localparam int DB = dir_bit(SIZE, AMT_W);
    localparam int AB = arith_bit(SIZE, AMT_W);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     wr_entry, head;
    logic [PTR_W-1:0] wptr, rptr;
    logic             push, full, empty;

    sync_fifo_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ctrl (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .out_ready_i (out_ready),
        .push_o      (push),
        .wptr_o      (wptr),
        .rptr_o      (rptr),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign in_ready  = ~full;
    assign out_valid = ~empty;

    // Pack the incoming command into the shared entry layout
    always_comb begin
        wr_entry                     = '0;
        wr_entry[DATA_LSB +: SIZE]   = in_data;
        wr_entry[AL +: AMT_W]        = in_amt;
        wr_entry[DB]                 = in_dir;
        wr_entry[AB]                 = in_arith;
    end

    // Storage array; not reset since only control state defines validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr] <= wr_entry;
    end

    // Head is zeroed when empty so unreset storage never leaks to the outputs
    assign head      = out_valid ? mem_q[rptr] : '0;
    assign out_data  = head[DATA_LSB +: SIZE];
    assign out_amt   = head[AL +: AMT_W];
    assign out_dir   = head[DB];
    assign out_arith = head[AB] & (head[DB] == DIR_RIGHT);
endmodule
